// File: rtl/pc060ha_flag_bank_if.sv
// Mailbox flag bank bus: strobes and mask in, flag/overrun/IRQ status out.
interface pc060ha_flag_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0] nFLAGSET;
    logic [CHANNELS-1:0] nFLAGRESET;
    logic [CHANNELS-1:0] IRQ_MASK;
    logic                OVR_CLR;
    logic [CHANNELS-1:0] FLAGOUT;
    logic [CHANNELS-1:0] OVERRUN;
    logic [CNT_W-1:0]    OVR_CNT;
    logic                FLAG_IRQ;

    modport master (
        output nFLAGSET, nFLAGRESET, IRQ_MASK, OVR_CLR,
        input  FLAGOUT, OVERRUN, OVR_CNT, FLAG_IRQ
    );

    modport slave (
        input  nFLAGSET, nFLAGRESET, IRQ_MASK, OVR_CLR,
        output FLAGOUT, OVERRUN, OVR_CNT, FLAG_IRQ
    );
endinterface

// File: rtl/pc060ha_flag_bank.sv
// Multi-channel mailbox flag bank with synchronised strobes, overrun
// tracking, saturating overrun counter and masked IRQ.
module pc060ha_flag_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SET_WINS    = 1,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    pc060ha_flag_bank_if.slave bus
);

    localparam int SW = CNT_W + 5;

    typedef logic [CHANNELS-1:0] ch_t;

    ch_t [SYNC_STAGES-1:0] sset_q, sclr_q;
    ch_t hset_q, hclr_q;
    ch_t flag_q, flag_d;
    ch_t ovr_q, ovr_d;
    ch_t ev_set, ev_clr, win_set, ovr_ev;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic irq_q, irq_d;
    logic [SW-1:0] sum;

    always_comb begin
        ev_set  = sset_q[SYNC_STAGES-1] & ~hset_q;
        ev_clr  = sclr_q[SYNC_STAGES-1] & ~hclr_q;
        win_set = (SET_WINS != 0) ? ev_set : (ev_set & ~ev_clr);
        flag_d  = win_set | (flag_q & ~ev_clr);
        ovr_ev  = win_set & flag_q;
        sum     = SW'(cnt_q);
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + SW'(ovr_ev[i]);
        end
        // Clear pulse wins over any overrun landing in the same cycle
        if (bus.OVR_CLR) begin
            ovr_d = '0;
            cnt_d = '0;
        end else begin
            ovr_d = ovr_q | ovr_ev;
            cnt_d = (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
        end
        irq_d = |(flag_q & bus.IRQ_MASK);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sset_q <= '1;
            sclr_q <= '1;
            hset_q <= '1;
            hclr_q <= '1;
            flag_q <= '0;
            ovr_q  <= '0;
            cnt_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            sset_q <= {sset_q[SYNC_STAGES-2:0], bus.nFLAGSET};
            sclr_q <= {sclr_q[SYNC_STAGES-2:0], bus.nFLAGRESET};
            hset_q <= sset_q[SYNC_STAGES-1];
            hclr_q <= sclr_q[SYNC_STAGES-1];
            flag_q <= flag_d;
            ovr_q  <= ovr_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
        end
    end

    assign bus.FLAGOUT  = flag_q;
    assign bus.OVERRUN  = ovr_q;
    assign bus.OVR_CNT  = cnt_q;
    assign bus.FLAG_IRQ = irq_q;

endmodule
